// File: rtl/z_core_lsu.sv
`default_nettype none
// ============================================================================
// Module   : z_core_lsu
// Purpose  : Load/store unit between the Z-Core control unit and the
//            axil_master simple memory port. It accepts one request at a time,
//            decodes the RISC-V funct3 access size, and generates bus-aligned
//            addresses, byte strobes and lane-replicated store data. It
//            sign/zero-extends load data, detects illegal sizes and bus
//            timeouts, and returns one response pulse per request.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            req_valid/req_ready           - request handshake
//            req_wen/funct3/addr/wdata     - request payload
//            resp_valid/resp_rdata/resp_err- single-cycle response
//            mem_req/wen/addr/wdata/wstrb  - bus transaction (registered payload)
//            mem_rdata/mem_ready/mem_busy  - bus completion and back-pressure
// Config   : Z_CORE_LSU_MISALIGN_CHECK_EN  - when defined, misaligned accesses
//            return err 1 without a bus access. When undefined, the offset is
//            rounded down to the natural alignment of the access size.
// Revision : 1.0 - initial release
// ============================================================================
module z_core_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_busy
);

    localparam int OFF_W = $clog2(STRB_WIDTH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit IS_64 = (DATA_WIDTH == 64);
    localparam logic [CNT_W-1:0] C_TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [1:0] C_ERR_OK      = 2'd0;
    localparam logic [1:0] C_ERR_MISALGN = 2'd1;
    localparam logic [1:0] C_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] C_ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [1:0]              size_code_q;   // log2 of access bytes
    logic [OFF_W-1:0]        off_q;
    logic                    unsigned_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic [1:0]              resp_err_q;
    logic                    mem_wen_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]            w_size_code;
    logic                  w_legal;
    logic                  w_misalign;
    logic [OFF_W-1:0]      w_raw_off;
    logic [OFF_W-1:0]      w_lane_mask;
    logic [OFF_W-1:0]      w_off;
    logic [3:0]            w_size_bytes;
    logic [STRB_WIDTH-1:0] w_strb_base;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [DATA_WIDTH-1:0] w_rep_wdata;
    logic [ADDR_WIDTH-1:0] w_aligned_addr;

    assign w_size_code = req_funct3[1:0];

    always_comb begin
        w_legal = 1'b0;
        if (req_wen) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                3'b011:                 w_legal = IS_64;
                default:                w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = IS_64;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    // Lane mask keeps only the offset bits at or above the access alignment.
    assign w_raw_off   = req_addr[OFF_W-1:0];
    assign w_lane_mask = {OFF_W{1'b1}} << w_size_code;
    assign w_off       = w_raw_off & w_lane_mask;

`ifdef Z_CORE_LSU_MISALIGN_CHECK_EN
    assign w_misalign = |(w_raw_off & ~w_lane_mask);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_size_bytes   = 4'd1 << w_size_code;
    // Shifting all-ones by >= width yields zero, so a full-width access
    // produces an all-ones base mask without special casing.
    assign w_strb_base    = ~({STRB_WIDTH{1'b1}} << w_size_bytes);
    assign w_strb         = w_strb_base << w_off;
    assign w_aligned_addr = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        w_rep_wdata = req_wdata;
        case (w_size_code)
            2'd0:    w_rep_wdata = {STRB_WIDTH{req_wdata[7:0]}};
            2'd1:    w_rep_wdata = {(STRB_WIDTH / 2){req_wdata[15:0]}};
            2'd2:    w_rep_wdata = {(STRB_WIDTH / 4){req_wdata[31:0]}};
            default: w_rep_wdata = req_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction and extension
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [6:0]            w_nbits;
    logic                  w_msb;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_field_mask;
    logic [DATA_WIDTH-1:0] w_load_ext;

    assign w_shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        w_nbits = 7'd8;
        w_msb   = w_shifted[7];
        case (size_code_q)
            2'd0:    begin w_nbits = 7'd8;              w_msb = w_shifted[7];            end
            2'd1:    begin w_nbits = 7'd16;             w_msb = w_shifted[15];           end
            2'd2:    begin w_nbits = 7'd32;             w_msb = w_shifted[31];           end
            default: begin w_nbits = 7'(DATA_WIDTH);    w_msb = w_shifted[DATA_WIDTH-1]; end
        endcase
    end

    assign w_sign       = w_msb & ~unsigned_q;
    assign w_field_mask = ~({DATA_WIDTH{1'b1}} << w_nbits);
    assign w_load_ext   = (w_shifted & w_field_mask) | ({DATA_WIDTH{w_sign}} & ~w_field_mask);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign mem_req   = (state_q == S_ISSUE) && !mem_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            size_code_q  <= '0;
            off_q        <= '0;
            unsigned_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= C_ERR_OK;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!w_legal) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= C_ERR_ILLEGAL;
                        end else if (w_misalign) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= C_ERR_MISALGN;
                        end else begin
                            state_q     <= S_ISSUE;
                            size_code_q <= w_size_code;
                            off_q       <= w_off;
                            unsigned_q  <= req_funct3[2];
                            mem_wen_q   <= req_wen;
                            mem_addr_q  <= w_aligned_addr;
                            mem_wdata_q <= req_wen ? w_rep_wdata : '0;
                            mem_wstrb_q <= req_wen ? w_strb : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_req) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= mem_wen_q ? '0 : w_load_ext;
                        resp_err_q   <= C_ERR_OK;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == C_TO_LAST)) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= C_ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_z_core_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_core_lsu
// Purpose  : Directed self-checking bench for z_core_lsu. Instance "a" is a
//            32-bit unit with a 4-cycle timeout; instance "b" is a 64-bit unit
//            with the default timeout. Expected responses are queued when each
//            request is driven and are checked when a response pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z_core_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance a : 32-bit, TIMEOUT_CYCLES = 4 ----------------
    logic        a_req_valid, a_req_wen, a_mem_ready, a_mem_busy;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_mem_rdata;
    logic        a_req_ready, a_resp_valid, a_mem_req, a_mem_wen;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_resp_err;
    logic [3:0]  a_mem_wstrb;

    z_core_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_req(a_mem_req), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata),
        .mem_ready(a_mem_ready), .mem_busy(a_mem_busy)
    );

    // ---------------- instance b : 64-bit, default timeout -------------------
    logic        b_req_valid, b_req_wen, b_mem_ready, b_mem_busy;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_mem_rdata;
    logic        b_req_ready, b_resp_valid, b_mem_req, b_mem_wen;
    logic [63:0] b_resp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [1:0]  b_resp_err;
    logic [7:0]  b_mem_wstrb;

    z_core_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_req(b_mem_req), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata),
        .mem_ready(b_mem_ready), .mem_busy(b_mem_busy)
    );

    // ---------------- scoreboard ---------------------------------------------
    typedef struct packed {
        logic [63:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] r, input logic [1:0] e);
        exp_t t;
        t.rdata = r;
        t.err   = e;
        exp_q.push_back(t);
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] r, input logic [1:0] e);
        exp_t t;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_unexpected_resp: observed rdata %0h err %0d expected no response", tag, r, e);
        end else begin
            t = exp_q.pop_front();
            chk({tag, "_rdata"}, r, t.rdata);
            chk({tag, "_err"}, {62'b0, e}, {62'b0, t.err});
        end
    endtask

    always @(negedge clk) begin
        if (a_resp_valid === 1'b1) pop_chk("a_resp", {32'b0, a_resp_rdata}, a_resp_err);
        if (b_resp_valid === 1'b1) pop_chk("b_resp", b_resp_rdata, b_resp_err);
    end

    // ---------------- helpers ------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns one cycle after the accepting edge.
    task automatic a_issue(input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        a_req_valid = 1'b1; a_req_wen = wen; a_req_funct3 = f3;
        a_req_addr = addr; a_req_wdata = wd;
        #1;
        chk("a_accept_ready", {63'b0, a_req_ready}, 64'd1);
        tick;
        a_req_valid = 1'b0;
    endtask

    // Called in a WAIT cycle: completes the bus access and checks the pulse.
    task automatic a_complete(input logic [31:0] rd);
        a_mem_rdata = rd;
        a_mem_ready = 1'b1;
        tick;
        a_mem_ready = 1'b0;
        chk("a_resp_pulse", {63'b0, a_resp_valid}, 64'd1);
        tick;
        chk("a_resp_single", {63'b0, a_resp_valid}, 64'd0);
        chk("a_ready_again", {63'b0, a_req_ready}, 64'd1);
    endtask

    // Called in the cycle after accept of a request that must not reach the bus.
    task automatic a_err_resp;
        chk("a_err_no_memreq", {63'b0, a_mem_req}, 64'd0);
        chk("a_err_resp_t1", {63'b0, a_resp_valid}, 64'd1);
        tick;
        chk("a_err_ready_t2", {63'b0, a_req_ready}, 64'd1);
    endtask

    task automatic b_issue(input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd);
        b_req_valid = 1'b1; b_req_wen = wen; b_req_funct3 = f3;
        b_req_addr = addr; b_req_wdata = wd;
        #1;
        chk("b_accept_ready", {63'b0, b_req_ready}, 64'd1);
        tick;
        b_req_valid = 1'b0;
    endtask

    task automatic b_complete(input logic [63:0] rd);
        b_mem_rdata = rd;
        b_mem_ready = 1'b1;
        tick;
        b_mem_ready = 1'b0;
        chk("b_resp_pulse", {63'b0, b_resp_valid}, 64'd1);
        tick;
        chk("b_ready_again", {63'b0, b_req_ready}, 64'd1);
    endtask

    // ---------------- directed sequence --------------------------------------
    initial begin
        a_req_valid = 0; a_req_wen = 0; a_req_funct3 = 0; a_req_addr = 0;
        a_req_wdata = 0; a_mem_rdata = 0; a_mem_ready = 0; a_mem_busy = 0;
        b_req_valid = 0; b_req_wen = 0; b_req_funct3 = 0; b_req_addr = 0;
        b_req_wdata = 0; b_mem_rdata = 0; b_mem_ready = 0; b_mem_busy = 0;

        // Reset state
        repeat (3) tick;
        chk("rst_ready_forced_low", {63'b0, a_req_ready}, 64'd0);
        chk("rst_resp_valid", {63'b0, a_resp_valid}, 64'd0);
        chk("rst_resp_err", {62'b0, a_resp_err}, 64'd0);
        chk("rst_resp_rdata", {32'b0, a_resp_rdata}, 64'd0);
        chk("rst_mem_req", {63'b0, a_mem_req}, 64'd0);
        chk("rst_mem_addr", {32'b0, a_mem_addr}, 64'd0);
        chk("rst_mem_wstrb", {60'b0, a_mem_wstrb}, 64'd0);
        chk("rst_mem_wdata", {32'b0, a_mem_wdata}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready_a", {63'b0, a_req_ready}, 64'd1);
        chk("rst_release_ready_b", {63'b0, b_req_ready}, 64'd1);

        // SB 0x103
        push(64'd0, 2'd0);
        a_issue(1'b1, 3'b000, 32'h103, 32'h0000_00AB);
        chk("sb_mem_req", {63'b0, a_mem_req}, 64'd1);
        chk("sb_mem_wen", {63'b0, a_mem_wen}, 64'd1);
        chk("sb_mem_addr", {32'b0, a_mem_addr}, 64'h100);
        chk("sb_mem_wstrb", {60'b0, a_mem_wstrb}, 64'b1000);
        chk("sb_mem_wdata", {32'b0, a_mem_wdata}, 64'hABAB_ABAB);
        tick;
        chk("sb_mem_req_once", {63'b0, a_mem_req}, 64'd0);
        chk("sb_addr_stable", {32'b0, a_mem_addr}, 64'h100);
        a_complete(32'h0);

        // LB 0x102 (signed)
        push(64'hFFFF_FFF0, 2'd0);
        a_issue(1'b0, 3'b000, 32'h102, 32'h0);
        chk("lb_mem_req", {63'b0, a_mem_req}, 64'd1);
        chk("lb_mem_wen", {63'b0, a_mem_wen}, 64'd0);
        chk("lb_mem_addr", {32'b0, a_mem_addr}, 64'h100);
        chk("lb_mem_wstrb", {60'b0, a_mem_wstrb}, 64'd0);
        tick;
        a_complete(32'h12F0_5634);

        // LBU 0x102
        push(64'h0000_00F0, 2'd0);
        a_issue(1'b0, 3'b100, 32'h102, 32'h0);
        tick;
        a_complete(32'h12F0_5634);

        // LH 0x102 with mem_busy high for 3 cycles after accept
        a_mem_busy = 1'b1;
        push(64'hFFFF_8765, 2'd0);
        a_issue(1'b0, 3'b001, 32'h102, 32'h0);
        chk("busy_t1_no_req", {63'b0, a_mem_req}, 64'd0);
        tick;
        chk("busy_t2_no_req", {63'b0, a_mem_req}, 64'd0);
        tick;
        chk("busy_t3_no_req", {63'b0, a_mem_req}, 64'd0);
        tick;
        a_mem_busy = 1'b0;
        #1;
        chk("busy_t4_req", {63'b0, a_mem_req}, 64'd1);
        tick;
        chk("busy_t5_no_req", {63'b0, a_mem_req}, 64'd0);
        a_complete(32'h8765_4321);

        // LW 0x100 with mem_ready withheld: timeout after 4 WAIT cycles
        push(64'd0, 2'd2);
        a_issue(1'b0, 3'b010, 32'h100, 32'h0);
        a_mem_rdata = 32'hCAFE_F00D;
        chk("to_mem_req", {63'b0, a_mem_req}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("to_wait_no_resp", {63'b0, a_resp_valid}, 64'd0);
        end
        tick;
        chk("to_resp_pulse", {63'b0, a_resp_valid}, 64'd1);
        tick;
        chk("to_ready_again", {63'b0, a_req_ready}, 64'd1);
        a_mem_ready = 1'b1;
        tick;
        chk("late_ready_no_resp0", {63'b0, a_resp_valid}, 64'd0);
        tick;
        a_mem_ready = 1'b0;
        chk("late_ready_no_resp1", {63'b0, a_resp_valid}, 64'd0);
        chk("late_ready_no_memreq", {63'b0, a_mem_req}, 64'd0);
        tick;
        chk("late_ready_no_resp2", {63'b0, a_resp_valid}, 64'd0);

        // LW 0x102: misaligned word
`ifdef Z_CORE_LSU_MISALIGN_CHECK_EN
        push(64'd0, 2'd1);
        a_issue(1'b0, 3'b010, 32'h102, 32'h0);
        a_err_resp;
`else
        push(64'hDEAD_BEEF, 2'd0);
        a_issue(1'b0, 3'b010, 32'h102, 32'h0);
        chk("lw_mis_mem_req", {63'b0, a_mem_req}, 64'd1);
        chk("lw_mis_mem_addr", {32'b0, a_mem_addr}, 64'h100);
        chk("lw_mis_mem_wstrb", {60'b0, a_mem_wstrb}, 64'd0);
        tick;
        a_complete(32'hDEAD_BEEF);
`endif

        // LD on a 32-bit unit: illegal
        push(64'd0, 2'd3);
        a_issue(1'b0, 3'b011, 32'h100, 32'h0);
        a_err_resp;

        // SH 0x102
        push(64'd0, 2'd0);
        a_issue(1'b1, 3'b001, 32'h102, 32'h1234_BEEF);
        chk("sh_mem_wstrb", {60'b0, a_mem_wstrb}, 64'b1100);
        chk("sh_mem_wdata", {32'b0, a_mem_wdata}, 64'hBEEF_BEEF);
        tick;
        a_complete(32'h0);

        // Store with a load-only funct3: illegal
        push(64'd0, 2'd3);
        a_issue(1'b1, 3'b100, 32'h100, 32'h55);
        a_err_resp;

        // 64-bit LWU 0x104
        push(64'h0000_0000_8000_0000, 2'd0);
        b_issue(1'b0, 3'b110, 32'h104, 64'h0);
        chk("b_lwu_mem_req", {63'b0, b_mem_req}, 64'd1);
        chk("b_lwu_mem_addr", {32'b0, b_mem_addr}, 64'h100);
        tick;
        b_complete(64'h8000_0000_0000_0000);

        // 64-bit LW 0x104 (signed)
        push(64'hFFFF_FFFF_8000_0000, 2'd0);
        b_issue(1'b0, 3'b010, 32'h104, 64'h0);
        tick;
        b_complete(64'h8000_0000_0000_0000);

        // 64-bit SD 0x108
        push(64'd0, 2'd0);
        b_issue(1'b1, 3'b011, 32'h108, 64'h1122_3344_5566_7788);
        chk("b_sd_mem_addr", {32'b0, b_mem_addr}, 64'h108);
        chk("b_sd_mem_wstrb", {56'b0, b_mem_wstrb}, 64'hFF);
        chk("b_sd_mem_wdata", b_mem_wdata, 64'h1122_3344_5566_7788);
        tick;
        b_complete(64'h0);

        // 64-bit SB 0x105
        push(64'd0, 2'd0);
        b_issue(1'b1, 3'b000, 32'h105, 64'h5A);
        chk("b_sb_mem_wstrb", {56'b0, b_mem_wstrb}, 64'h20);
        chk("b_sb_mem_wdata", b_mem_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
        tick;
        b_complete(64'h0);

        // 64-bit LD 0x110
        push(64'h8877_6655_4433_2211, 2'd0);
        b_issue(1'b0, 3'b011, 32'h110, 64'h0);
        tick;
        b_complete(64'h8877_6655_4433_2211);

        tick;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z_core_lsu.md
# z_core_lsu

Parametrised load/store unit between the Z-Core control unit and the `axil_master` simple memory port. It accepts one load or store request at a time and encodes RV32/RV64 funct3 sizes (byte, half, word and, when 64-bit, double). It generates byte strobes, replicates write data across lanes, extracts and sign/zero-extends read data, and returns a single response with an error code. It replaces the fixed full-word memory path and adds access-size handling, misalignment detection and a bus timeout.

## Interface
- `DATA_WIDTH`, 32: bus and register width; legal values are 32 or 64.
- `ADDR_WIDTH`, 32: address width.
- `STRB_WIDTH`, DATA_WIDTH/8: byte lanes.
- `TIMEOUT_CYCLES`, 256: maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle, request accepted this cycle.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V load/store funct3.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_err`  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal funct3.
- `mem_req`  out  1  one-cycle transaction start.
- `mem_wen`  out  1  transaction is a write.
- `mem_addr`  out  ADDR_WIDTH  bus-aligned address (low log2(STRB_WIDTH) bits zero).
- `mem_wdata`  out  DATA_WIDTH  lane-replicated write data.
- `mem_wstrb`  out  STRB_WIDTH  byte strobes; all zero for reads.
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_ready`.
- `mem_ready`  in  1  transaction complete.
- `mem_busy`  in  1  master occupied; no `mem_req` allowed.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- `req_ready` = (state == IDLE). The request is captured into registers on the accepting edge.
- IDLE → RESP: the request is illegal or (with the configuration macro) misaligned; no bus traffic occurs.
- IDLE → ISSUE: all other accepted requests.
- ISSUE: `mem_req` = !`mem_busy`, combinational. Go to WAIT on the cycle `mem_req` is high; otherwise stay in ISSUE.
- WAIT: `mem_ready` goes to RESP and latches the extended data. The timeout counter reaching TIMEOUT_CYCLES goes to RESP with err 2. The counter clears on entry to WAIT.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE.
- `mem_ready` is ignored outside WAIT, including a late ready after a timeout.
- Size encoding:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011 LD/SD and 110 LWU are legal only when DATA_WIDTH = 64.
  - 111 is always illegal.
  - Stores accept only 000/001/010, plus 011 at 64-bit.
- Offset `off` = req_addr[log2(STRB_WIDTH)-1:0]; `mem_addr` = req_addr with those bits cleared.
- Stores: `mem_wstrb` = ((1<<size_bytes)-1) << off. `mem_wdata` = low size_bytes of `req_wdata` replicated across the bus.
- Loads: select the size_bytes field at `off` from `mem_rdata`. Signed funct3 sign-extends to DATA_WIDTH; unsigned funct3 zero-extends.
- `mem_wen`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered. They stay stable from ISSUE through WAIT.

## Timing
- Reset: state IDLE, and `resp_valid`, `resp_rdata`, `resp_err`, `mem_req`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wstrb` all 0. `req_ready` = 1 on the first cycle after `rst` falls; it is forced to 0 while `rst` is high.
- Reset mid-transaction abandons the access with no response. `axil_master` shares this reset.
- Normal latency with accept at edge T:
  - `mem_req` is high in cycle T+1 if `mem_busy` is low.
  - Ready arrives in cycle W ≥ T+2.
  - `resp_valid` is high in cycle W+1.
  - `req_ready` is high again in cycle W+2.
- Error latency: `resp_valid` in cycle T+1; `req_ready` in cycle T+2.
- Timeout: RESP is entered after TIMEOUT_CYCLES WAIT cycles without `mem_ready`.
- `mem_req` is never high in two consecutive cycles and never while `mem_busy` = 1.

## Configuration
- `Z_CORE_LSU_MISALIGN_CHECK_EN` defined:
  - Misaligned accesses get err 1 with no bus transaction. These are LH/LHU/SH with addr[0] ≠ 0, word with addr[1:0] ≠ 0, and double with addr[2:0] ≠ 0.
- Undefined:
  - `off` is rounded down to the natural alignment of the access size.
  - The access proceeds normally and err 1 is never produced.

## Test plan
- 32-bit SB, addr 0x103, wdata 0x000000AB → mem_addr 0x100, wstrb 0b1000, wdata 0xABABABAB, resp_err 0.
- 32-bit LB, addr 0x102, mem_rdata 0x12F0_5634 → resp_rdata 0xFFFFFFF0. LBU on the same access → 0x000000F0.
- `mem_busy` high for 3 cycles after accept → mem_req in cycle T+4 only, exactly one pulse, response follows.
- TIMEOUT_CYCLES = 4 and `mem_ready` withheld → resp_err 2, resp_rdata 0. A later `mem_ready` produces no second response.
- With the macro, LW at 0x102 → resp_valid in cycle T+1, err 1, no mem_req. Without the macro → access to 0x100, wstrb 0 read, err 0.
- 32-bit LD (funct3 011) → err 3, no mem_req. 64-bit LWU at 0x104, rdata 0x80000000_00000000 → resp_rdata 0x0000_0000_8000_0000.
